// File: rtl/communication.sv
// rtl/communication.sv - SPI mode-0 slave receiver: oversampled SCLK/MOSI/select, 16-bit words out
`timescale 1ns/1ps
module communication #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  active,
  output logic [DATA_WIDTH-1:0] audio_out,
  output logic                  data_ready
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]  act_sync_q, act_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   audio_q, audio_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ready_q, ready_d;

  logic sclk_s, mosi_s, act_s, sclk_rise;

  // mosi shares the sclk pipeline depth so the sampled bit lines up with the detected rise
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign act_s     = act_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  assign audio_out  = audio_q;
  assign data_ready = ready_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    act_sync_d  = {act_sync_q[SYNC_STAGES-2:0], active};
    sclk_prev_d = sclk_s;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    audio_d = audio_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        shift_d = '0;
        if (act_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (!act_s) begin
          // select dropped mid-word: discard partial data silently
          state_d = IDLE;
          count_d = '0;
          shift_d = '0;
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
          count_d = count_q + CW'(1);
          if (count_q == CW'(DATA_WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        audio_d = shift_q;
        ready_d = 1'b1;
        count_d = '0;
        state_d = act_s ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      act_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      audio_q     <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      act_sync_q  <= act_sync_d;
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      audio_q     <= audio_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_communication.sv
// tb/tb_communication.sv - self-checking bench for the communication SPI receiver
`timescale 1ns/1ps
module tb_communication;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        sclk_in;
  logic        mosi_in;
  logic        active;
  logic [15:0] audio_out;
  logic        data_ready;

  int  checks = 0;
  int  errors = 0;
  int  pulses = 0;
  time t_last = 0;
  logic        prev_dr  = 1'b0;
  logic [15:0] prev_out = 16'h0;

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic [15:0] exp_out;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[8];

  communication #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .sclk_in   (sclk_in),
    .mosi_in   (mosi_in),
    .active    (active),
    .audio_out (audio_out),
    .data_ready(data_ready)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Continuous monitor: strobe width, strobe latency after the last SCLK rise, output hold
  always @(negedge clk_25mhz) begin
    if (data_ready) begin
      pulses++;
      checks++;
      if (prev_dr) begin
        errors++;
        $display("FAIL strobe_width: data_ready high on consecutive cycles, required 1 cycle");
      end
      checks++;
      if ($time - t_last > 180) begin
        errors++;
        $display("FAIL strobe_latency: %0t ns after last sclk rise, required <= 180 ns", $time - t_last);
      end
    end else if (!reset && audio_out !== prev_out) begin
      checks++;
      errors++;
      $display("FAIL output_hold: audio_out changed %h -> %h without data_ready", prev_out, audio_out);
    end
    prev_dr  = data_ready;
    prev_out = audio_out;
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      mosi_in = w[15-i];
      #(half);
      sclk_in = 1'b1;
      t_last  = $time;
      #(half);
      sclk_in = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n, input int half);
    active = 1'b1;
    #200;
    send_bits(w, n, half);
    #300;
    active = 1'b0;
    #300;
  endtask

  logic [15:0] model_out;
  int          p0;
  logic [15:0] rw;
  int          rn;
  int          rh;

  initial begin
    reset   = 1'b1;
    sclk_in = 1'b0;
    mosi_in = 1'b0;
    active  = 1'b0;
    #90;
    check("reset_audio_out", 32'(audio_out), 32'h0);
    check("reset_data_ready", 32'(data_ready), 32'h0);
    #10;
    reset = 1'b0;
    #200;

    vecs[0] = '{16'hA5A5, 16, 16'hA5A5, 1};
    vecs[1] = '{16'hBEEF, 16, 16'hBEEF, 1};
    vecs[2] = '{16'h5555, 8,  16'hBEEF, 0};
    vecs[3] = '{16'h1234, 16, 16'h1234, 1};
    vecs[4] = '{16'h0000, 16, 16'h0000, 1};
    vecs[5] = '{16'hFFFF, 1,  16'h0000, 0};
    vecs[6] = '{16'h8001, 15, 16'h0000, 0};
    vecs[7] = '{16'h8001, 16, 16'h8001, 1};

    foreach (vecs[k]) begin
      p0 = pulses;
      frame(vecs[k].data, vecs[k].nbits, 250);
      check($sformatf("vec%0d_pulses", k), 32'(pulses - p0), 32'(vecs[k].exp_pulses));
      check($sformatf("vec%0d_audio_out", k), 32'(audio_out), 32'(vecs[k].exp_out));
    end

    // Continuous stream with select held high
    p0 = pulses;
    active = 1'b1;
    #200;
    send_bits(16'h0001, 16, 250);
    #300;
    check("stream_w1_pulses", 32'(pulses - p0), 32'd1);
    check("stream_w1_audio_out", 32'(audio_out), 32'h0001);
    send_bits(16'hFFFF, 16, 250);
    #300;
    check("stream_w2_pulses", 32'(pulses - p0), 32'd2);
    check("stream_w2_audio_out", 32'(audio_out), 32'hFFFF);
    active = 1'b0;
    #300;

    // Reset part-way through a word
    active = 1'b1;
    #200;
    send_bits(16'hCAFE, 10, 250);
    #100;
    reset = 1'b1;
    #5;
    check("midreset_audio_out", 32'(audio_out), 32'h0);
    check("midreset_data_ready", 32'(data_ready), 32'h0);
    #95;
    active = 1'b0;
    #40;
    reset = 1'b0;
    #200;
    p0 = pulses;
    frame(16'h5A5A, 16, 250);
    check("after_reset_pulses", 32'(pulses - p0), 32'd1);
    check("after_reset_audio_out", 32'(audio_out), 32'h5A5A);

    // Randomised frames: the model keeps the last fully received word
    model_out = 16'h5A5A;
    for (int r = 0; r < 25; r++) begin
      rw = 16'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      rh = int'($urandom_range(130, 300));
      p0 = pulses;
      frame(rw, rn, rh);
      if (rn == 16) model_out = rw;
      check($sformatf("rand%0d_pulses", r), 32'(pulses - p0), (rn == 16) ? 32'd1 : 32'd0);
      check($sformatf("rand%0d_audio_out", r), 32'(audio_out), 32'(model_out));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
